// File: rtl/axi_pkg.sv
// AXI3 burst/response encodings, FSM state types and the burst address-advance helper
// shared by the SRAM slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Illegal WRAP lengths and the reserved burst type both fall back to INCR.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [63:0] step;
    logic [63:0] mask;
    logic [63:0] res;
    step = 64'd1 << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: res = addr;
      BURST_WRAP: begin
        if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
          res = (addr & ~mask) | ((addr + step) & mask);
        else
          res = addr + step;
      end
      default: res = addr + step;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word array with one byte-enabled write port and one registered read port.
// Read-first: a read and write of the same word in one cycle returns the old word.
module axi_sram_mem #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH/8-1:0]      wbe,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         re,
  input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave SRAM: independent write (AW/W/B) and read (AR/R) FSMs, one outstanding
// transaction each, FIXED/INCR/WRAP bursts with byte strobes.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 31,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                    i_aclk,
  input  logic                    i_areset,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [ID_WIDTH-1:0]     i_wid,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned BYTE_BITS  = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_BITS   = $clog2(MEM_DEPTH);
  localparam logic [2:0]  MAX_SIZE   = 3'(BYTE_BITS);

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > MAX_SIZE) ? MAX_SIZE : size;
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    return |addr[ADDR_WIDTH-1:BYTE_BITS+IDX_BITS];
  endfunction

  function automatic logic [IDX_BITS-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    return addr[BYTE_BITS +: IDX_BITS];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] addr,
      input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    return ADDR_WIDTH'(next_addr(64'(addr), size, len, burst));
  endfunction

  wr_state_t             w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err, w_err_next, w_last_beat;

  rd_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;

  logic                  mem_we, mem_re;
  logic [IDX_BITS-1:0]   mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic unused_wid;
  assign unused_wid = ^i_wid;

  always_comb begin
    w_last_beat = (w_cnt == w_len);
    w_err_next  = w_err | out_of_range(w_addr) | (i_wlast != w_last_beat);
    mem_we      = (w_state == W_DATA) && i_wvalid && !out_of_range(w_addr);
    // r_addr always holds the address of the beat to be fetched next.
    mem_re      = ((r_state == R_IDLE) && i_arvalid) ||
                  ((r_state == R_DATA) && i_rready && (r_cnt != r_len));
    mem_raddr   = (r_state == R_IDLE) ? word_index(i_araddr) : word_index(r_addr);
  end

  axi_sram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk  (i_aclk),
    .we   (mem_we),
    .waddr(word_index(w_addr)),
    .wbe  (i_wstrb),
    .wdata(i_wdata),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      w_state   <= W_IDLE;
      o_awready <= 1'b1;
      o_wready  <= 1'b0;
      o_bvalid  <= 1'b0;
      o_bid     <= '0;
      o_bresp   <= RESP_OKAY;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (i_awvalid) begin
          w_id      <= i_awid;
          w_addr    <= i_awaddr;
          w_len     <= i_awlen;
          w_size    <= clamp_size(i_awsize);
          w_burst   <= i_awburst;
          w_cnt     <= '0;
          w_err     <= 1'b0;
          o_awready <= 1'b0;
          o_wready  <= 1'b1;
          w_state   <= W_DATA;
        end
        W_DATA: if (i_wvalid) begin
          w_addr <= advance(w_addr, w_size, w_len, w_burst);
          w_err  <= w_err_next;
          if (w_last_beat) begin
            o_wready <= 1'b0;
            o_bvalid <= 1'b1;
            o_bid    <= w_id;
            o_bresp  <= w_err_next ? RESP_SLVERR : RESP_OKAY;
            w_state  <= W_RESP;
          end else begin
            w_cnt <= w_cnt + 8'd1;
          end
        end
        W_RESP: if (i_bready) begin
          o_bvalid  <= 1'b0;
          o_awready <= 1'b1;
          w_state   <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state   <= R_IDLE;
      o_arready <= 1'b1;
      o_rvalid  <= 1'b0;
      o_rlast   <= 1'b0;
      o_rid     <= '0;
      o_rresp   <= RESP_OKAY;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (i_arvalid) begin
          r_addr    <= advance(i_araddr, clamp_size(i_arsize), i_arlen, i_arburst);
          r_size    <= clamp_size(i_arsize);
          r_len     <= i_arlen;
          r_burst   <= i_arburst;
          r_cnt     <= '0;
          o_rid     <= i_arid;
          o_rresp   <= out_of_range(i_araddr) ? RESP_SLVERR : RESP_OKAY;
          o_rlast   <= (i_arlen == 8'd0);
          o_rvalid  <= 1'b1;
          o_arready <= 1'b0;
          r_state   <= R_DATA;
        end
        R_DATA: if (i_rready) begin
          if (r_cnt == r_len) begin
            o_rvalid  <= 1'b0;
            o_rlast   <= 1'b0;
            o_arready <= 1'b1;
            r_state   <= R_IDLE;
          end else begin
            r_addr  <= advance(r_addr, r_size, r_len, r_burst);
            r_cnt   <= r_cnt + 8'd1;
            o_rlast <= ((r_cnt + 8'd1) == r_len);
            o_rresp <= out_of_range(r_addr) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // The array output register only moves on a fetch, so data stays stable under stalls.
  assign o_rdata = (o_rvalid && o_rresp == RESP_OKAY) ? mem_rdata : '0;

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 slave memory that consumes the write/read traffic of the bus-top AXI master. It is the direct downstream stage of that master.
- Holds a synchronous word array and handles FIXED, INCR and WRAP bursts with byte strobes.
- Write and read paths are independent, with one outstanding transaction per direction.
- Used as the bus-top bench target and as on-chip scratch RAM.

Parameters:
- ID_WIDTH, 4, AXI ID width, matches the master.
- ADDR_WIDTH, 31, byte-address width, matches the master.
- DATA_WIDTH, 128, data width in bits; allowed values 32, 64, 128.
- MEM_DEPTH, 256, number of DATA_WIDTH words; power of two.

Ports:
- i_aclk  in  1  clock; all logic on rising edge.
- i_areset  in  1  synchronous active-high reset.
- i_awid, i_awaddr, i_awlen, i_awsize, i_awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload.
- i_awvalid in 1, o_awready out 1  AW handshake.
- i_wid, i_wdata, i_wstrb, i_wlast  in  ID_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1  W payload; i_wid is ignored.
- i_wvalid in 1, o_wready out 1  W handshake.
- o_bid, o_bresp  out  ID_WIDTH/2  B payload.
- o_bvalid out 1, i_bready in 1  B handshake.
- i_arid, i_araddr, i_arlen, i_arsize, i_arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  AR payload.
- i_arvalid in 1, o_arready out 1  AR handshake.
- o_rid, o_rdata, o_rresp, o_rlast  out  ID_WIDTH/DATA_WIDTH/2/1  R payload.
- o_rvalid out 1, i_rready in 1  R handshake.
- Master lock/cache/prot outputs are not consumed and are left unconnected at top level.

Behaviour:
- Reset: all FSMs go to IDLE.
  - o_awready=1, o_arready=1; o_wready=0, o_bvalid=0, o_rvalid=0, o_rlast=0.
  - o_bid, o_rid, o_rdata, o_bresp, o_rresp all 0.
  - Memory contents are not reset.
  - A reset in the middle of a burst abandons it; no B/R beat is issued afterwards.
- Write FSM, IDLE -> WDATA -> WRESP -> IDLE:
  - IDLE: o_awready=1. On AW handshake, latch id, addr, len, size, burst and set the beat counter to 0; go to WDATA with o_awready=0.
  - WDATA: o_wready=1. On each W handshake, write the bytes enabled by i_wstrb into word addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] modulo MEM_DEPTH, then advance the address.
  - WDATA exits on the W handshake where the counter equals len. i_wlast is not used to end the burst.
  - WDATA -> WRESP: o_bvalid=1 and o_bid=the latched id.
  - WRESP holds until i_bready; o_awready returns high the cycle after the B handshake.
- B response value:
  - OKAY (00) normally.
  - SLVERR (10) if any beat address is >= MEM_DEPTH*DATA_WIDTH/8. Out-of-range beats are not written.
  - SLVERR (10) if i_wlast disagrees with the counter on any beat.
- Read FSM, IDLE -> RDATA -> IDLE:
  - IDLE: o_arready=1. On AR handshake, latch the burst fields, read the first word, and go to RDATA.
  - RDATA: o_rvalid=1 from the cycle after the AR handshake (1-cycle latency).
  - o_rdata, o_rid, o_rresp and o_rlast are held stable while o_rvalid=1 and i_rready=0.
  - On an R handshake with the counter < len, the next beat is presented in the following cycle. There are no bubbles when i_rready stays high.
  - o_rlast=1 only when the counter equals len. The handshake on that beat returns the FSM to IDLE.
- R response value: OKAY per beat, or SLVERR with o_rdata=0 for out-of-range beats.
- Address advance, step = 1<<size:
  - FIXED: the address is unchanged.
  - INCR: addr + step.
  - WRAP: container = (len+1)*step. Next address = (addr & ~(container-1)) | ((addr+step) & (container-1)).
  - WRAP is legal only for len in {1,3,7,15}; any other len is treated as INCR.
  - A size larger than log2(DATA_WIDTH/8) is clamped to the maximum.
  - Reserved burst type 11 is treated as INCR.
- Narrow transfers: the word index comes from the address. Strobes are applied exactly as driven; no lane steering is done.
- Simultaneous events:
  - A write and a read may be active in the same cycle.
  - A write and a read to the same word in the same cycle: the read returns the old data (read-first array).
- Counters are 8 bits; len=255 gives 256 beats with no overflow.

Decomposition:
- Package axi_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - response encodings RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - a function next_addr(addr, size, len, burst).
- One sub-module, axi_sram_mem: a dual-port array (one write port with byte enables, one registered read port), parameterised by DATA_WIDTH and MEM_DEPTH.

Test Plan:
- Single write, then read: AW addr 0x100, len 0, size 4, INCR; wdata 0xA5..., wstrb all ones -> B OKAY with the same id. The read of 0x100 returns the identical data, with rlast=1 and rvalid exactly 1 cycle after the AR handshake.
- INCR burst with backpressure: write len 3 at 0x0 with data 1..4. Read it back while toggling i_rready 1,0,0,1 -> beats 1..4 in order, each held stable during stalls, rlast on beat 4 only.
- WRAP: write len 3, size 4 at 0x20 -> beats land at words 2,3,0,1. INCR readback from 0x0 returns beats 3,4,1,2.
- Strobes and FIXED: 4-beat FIXED write to 0x40 with strobes 0x000F, 0x00F0, 0x0F00, 0xF000 -> the word is the merge of all four beats.
- Errors: write beyond MEM_DEPTH*16 -> B SLVERR and memory unchanged. A len 1 write with wlast asserted on beat 0 -> SLVERR.
- Concurrency and reset: overlapping write and read bursts complete correctly. Asserting i_areset mid-burst -> the next cycle shows o_awready=1, o_arready=1, o_bvalid=0 and o_rvalid=0.
